// File: rtl/t05_sram_arbiter.sv
// Shares one 32-bit Wishbone-style SRAM port among the header decoder, translation stage and
// output writer: round-robin grant, 128-bit codebook accesses as four beats, per-beat ack timeout.
module t05_sram_arbiter #(
  parameter logic [31:0] CB_BASE  = 32'h3300_0000,
  parameter logic [31:0] OUT_BASE = 32'h3300_1000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hd_req,
  input  logic [7:0]   hd_index,
  input  logic [127:0] hd_path,
  output logic         hd_ack,
  input  logic         tr_req,
  input  logic [7:0]   tr_index,
  output logic [127:0] tr_path,
  output logic         tr_ack,
  input  logic         wr_req,
  input  logic [31:0]  wr_addr,
  input  logic [31:0]  wr_data,
  output logic         wr_ack,
  output logic         bus_cyc,
  output logic         bus_we,
  output logic [31:0]  bus_adr,
  output logic [31:0]  bus_dat_o,
  output logic [3:0]   bus_sel,
  input  logic [31:0]  bus_dat_i,
  input  logic         bus_ack,
  output logic         err,
  output logic [1:0]   grant
);

  typedef enum logic [1:0] {StIdle, StBeat, StDone} state_e;

  localparam logic [1:0] GntNone = 2'd0;
  localparam logic [1:0] GntHd   = 2'd1;
  localparam logic [1:0] GntTr   = 2'd2;
  localparam logic [1:0] GntWr   = 2'd3;
  // Abort on the cycle the counter would reach TIMEOUT.
  localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

  state_e       state_q, state_d;
  logic [1:0]   grant_q, grant_d, rr_q, rr_d, k_q, k_d, winner, cand;
  logic [7:0]   tmo_q, tmo_d, idx_q, idx_d;
  logic [127:0] path_q, path_d, tr_path_q, tr_path_d;
  logic [31:0]  wadr_q, wadr_d, wdat_q, wdat_d;
  logic [31:0]  bus_adr_q, bus_adr_d, bus_dat_q, bus_dat_d;
  logic         bus_cyc_q, bus_cyc_d, bus_we_q, bus_we_d;
  logic [3:0]   bus_sel_q, bus_sel_d, req_vec;
  logic         hd_ack_q, hd_ack_d, tr_ack_q, tr_ack_d, wr_ack_q, wr_ack_d, err_q, err_d;

  function automatic logic [1:0] rr_next(input logic [1:0] c);
    case (c)
      GntHd:   return GntTr;
      GntTr:   return GntWr;
      default: return GntHd;
    endcase
  endfunction

  function automatic logic [31:0] word_of(input logic [127:0] p, input logic [1:0] k);
    case (k)
      2'd0:    return p[127:96];
      2'd1:    return p[95:64];
      2'd2:    return p[63:32];
      default: return p[31:0];
    endcase
  endfunction

  // rr_q holds the client checked first, so it starts at wr out of reset.
  assign req_vec = {wr_req, tr_req, hd_req, 1'b0};

  always_comb begin
    winner = GntNone;
    cand   = rr_q;
    for (int i = 0; i < 3; i++) begin
      if (winner == GntNone && req_vec[cand]) winner = cand;
      cand = rr_next(cand);
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    k_d       = k_q;
    tmo_d     = tmo_q;
    idx_d     = idx_q;
    path_d    = path_q;
    wadr_d    = wadr_q;
    wdat_d    = wdat_q;
    tr_path_d = tr_path_q;
    hd_ack_d  = 1'b0;
    tr_ack_d  = 1'b0;
    wr_ack_d  = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (winner != GntNone) begin
          state_d = StBeat;
          grant_d = winner;
          k_d     = 2'd0;
          tmo_d   = 8'd0;
          idx_d   = (winner == GntTr) ? tr_index : hd_index;
          path_d  = hd_path;
          wadr_d  = wr_addr;
          wdat_d  = wr_data;
          // Unreceived words of an aborted read must read back as zero.
          if (winner == GntTr) tr_path_d = '0;
        end
      end
      StBeat: begin
        if (bus_ack) begin
          if (grant_q == GntTr) begin
            for (int j = 0; j < 4; j++) begin
              if (k_q == 2'(j)) tr_path_d[127-32*j -: 32] = bus_dat_i;
            end
          end
          if (grant_q != GntWr && k_q != 2'd3) begin
            k_d   = k_q + 2'd1;
            tmo_d = 8'd0;
          end else begin
            state_d = StDone;
          end
        end else if (tmo_q == TmoLast) begin
          state_d = StDone;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
        if (state_d == StDone) begin
          hd_ack_d = (grant_q == GntHd);
          tr_ack_d = (grant_q == GntTr);
          wr_ack_d = (grant_q == GntWr);
        end
      end
      StDone: begin
        state_d = StIdle;
        rr_d    = rr_next(grant_q);
        grant_d = GntNone;
      end
      default: state_d = StIdle;
    endcase

    bus_cyc_d = (state_d == StBeat);
    bus_we_d  = 1'b0;
    bus_sel_d = 4'h0;
    bus_adr_d = 32'h0;
    bus_dat_d = 32'h0;
    if (bus_cyc_d) begin
      bus_sel_d = 4'hF;
      bus_we_d  = (grant_d != GntTr);
      if (grant_d == GntWr) begin
        bus_adr_d = OUT_BASE + {wadr_d[31:2], 2'b00};
        bus_dat_d = wdat_d;
      end else begin
        bus_adr_d = CB_BASE + {20'd0, idx_d, 4'd0} + {28'd0, k_d, 2'b00};
        if (grant_d == GntHd) bus_dat_d = word_of(path_d, k_d);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      grant_q   <= GntNone;
      rr_q      <= GntWr;
      k_q       <= 2'd0;
      tmo_q     <= 8'd0;
      idx_q     <= 8'd0;
      path_q    <= '0;
      wadr_q    <= 32'h0;
      wdat_q    <= 32'h0;
      tr_path_q <= '0;
      bus_cyc_q <= 1'b0;
      bus_we_q  <= 1'b0;
      bus_sel_q <= 4'h0;
      bus_adr_q <= 32'h0;
      bus_dat_q <= 32'h0;
      hd_ack_q  <= 1'b0;
      tr_ack_q  <= 1'b0;
      wr_ack_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      k_q       <= k_d;
      tmo_q     <= tmo_d;
      idx_q     <= idx_d;
      path_q    <= path_d;
      wadr_q    <= wadr_d;
      wdat_q    <= wdat_d;
      tr_path_q <= tr_path_d;
      bus_cyc_q <= bus_cyc_d;
      bus_we_q  <= bus_we_d;
      bus_sel_q <= bus_sel_d;
      bus_adr_q <= bus_adr_d;
      bus_dat_q <= bus_dat_d;
      hd_ack_q  <= hd_ack_d;
      tr_ack_q  <= tr_ack_d;
      wr_ack_q  <= wr_ack_d;
      err_q     <= err_d;
    end
  end

  assign grant     = grant_q;
  assign tr_path   = tr_path_q;
  assign bus_cyc   = bus_cyc_q;
  assign bus_we    = bus_we_q;
  assign bus_sel   = bus_sel_q;
  assign bus_adr   = bus_adr_q;
  assign bus_dat_o = bus_dat_q;
  assign hd_ack    = hd_ack_q;
  assign tr_ack    = tr_ack_q;
  assign wr_ack    = wr_ack_q;
  assign err       = err_q;

endmodule
